shared_read_arb: RTL and testbench

SHARED_READ_ARB -- requirements
Module: shared_read_arb

---
 rtl/shared_read_arb_if.sv | 45 ++++
 rtl/shared_read_arb.sv | 117 +++++++++++
 tb/tb_shared_read_arb.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/shared_read_arb_if.sv
// Bus bundle for the shared read arbiter.
// Groups both core request/response channels, the shared memory read port and the
// sticky error flag. Clock and reset stay plain ports on the arbiter.
//   slave  : arbiter side (takes requests and memory returns, drives grants and responses)
//   master : environment side (cores and memory)
// Signals:
//   a_req/b_req      core read request, held with its address until accepted
//   a_addr/b_addr    [15:1] word address
//   a_ready/b_ready  request accepted this cycle
//   a_rvalid/b_rvalid, a_rdata/b_rdata  one-cycle read response
//   m_valid/m_raddr/m_rtag  address issue to memory, tag 0 = core A, 1 = core B
//   m_rdata          [16:0] memory return, bit 16 = echoed tag
//   err              sticky tag-mismatch flag
interface shared_read_arb_if;
  logic        a_req;
  logic [15:1] a_addr;
  logic        a_ready;
  logic        a_rvalid;
  logic [15:0] a_rdata;

  logic        b_req;
  logic [15:1] b_addr;
  logic        b_ready;
  logic        b_rvalid;
  logic [15:0] b_rdata;

  logic        m_valid;
  logic [15:1] m_raddr;
  logic        m_rtag;
  logic [16:0] m_rdata;

  logic        err;

  modport slave (
    input  a_req, a_addr, b_req, b_addr, m_rdata,
    output a_ready, a_rvalid, a_rdata, b_ready, b_rvalid, b_rdata,
    output m_valid, m_raddr, m_rtag, err
  );

  modport master (
    output a_req, a_addr, b_req, b_addr, m_rdata,
    input  a_ready, a_rvalid, a_rdata, b_ready, b_rvalid, b_rdata,
    input  m_valid, m_raddr, m_rtag, err
  );
endinterface

// File: rtl/shared_read_arb.sv
// Two-core round-robin arbiter in front of a single fixed-latency memory read port.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    shared_read_arb_if.slave (core A/B channels, memory port, err)
// Parameter:
//   LAT    memory read latency in cycles from m_raddr to m_rdata (1..4)
// One request is granted per cycle; the grant is registered into the issue stage, and a
// LAT-deep {valid, tag} pipe tracks each read so the return is routed to its requester.
module shared_read_arb #(
  parameter int unsigned LAT = 2
) (
  input logic               clk,
  input logic               reset,
  shared_read_arb_if.slave  bus
);

  // Round-robin pointer: 1 means core B was granted most recently.
  logic last_b_q, last_b_d;

  // Issue stage.
  logic        m_valid_q, m_valid_d;
  logic [15:1] m_raddr_q, m_raddr_d;
  logic        m_rtag_q, m_rtag_d;

  // In-flight tracking, index LAT-1 is the oldest entry.
  logic [LAT-1:0] inf_vld_q, inf_vld_d;
  logic [LAT-1:0] inf_tag_q, inf_tag_d;

  logic err_q, err_d;

  logic grant_a, grant_b;
  logic oldest_vld, oldest_tag;

  // Grant is combinational; forced low during reset so nothing is accepted then.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!reset) begin
      if (bus.a_req && bus.b_req) begin
        if (last_b_q) grant_a = 1'b1;
        else          grant_b = 1'b1;
      end else if (bus.a_req) begin
        grant_a = 1'b1;
      end else if (bus.b_req) begin
        grant_b = 1'b1;
      end
    end
  end

  always_comb begin
    last_b_d  = last_b_q;
    m_valid_d = grant_a | grant_b;
    m_raddr_d = '0;
    m_rtag_d  = grant_b;
    if (grant_a) begin
      last_b_d  = 1'b0;
      m_raddr_d = bus.a_addr;
    end else if (grant_b) begin
      last_b_d  = 1'b1;
      m_raddr_d = bus.b_addr;
    end
  end

  always_comb begin
    inf_vld_d    = '0;
    inf_tag_d    = '0;
    inf_vld_d[0] = m_valid_q;
    inf_tag_d[0] = m_rtag_q;
    for (int unsigned i = 1; i < LAT; i++) begin
      inf_vld_d[i] = inf_vld_q[i-1];
      inf_tag_d[i] = inf_tag_q[i-1];
    end
  end

  assign oldest_vld = inf_vld_q[LAT-1];
  assign oldest_tag = inf_tag_q[LAT-1];

  // A mismatched echo still routes by the stored tag; it only raises err.
  always_comb begin
    err_d = err_q;
    if (oldest_vld && (bus.m_rdata[16] != oldest_tag)) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_b_q  <= 1'b1;
      m_valid_q <= 1'b0;
      m_raddr_q <= '0;
      m_rtag_q  <= 1'b0;
      inf_vld_q <= '0;
      inf_tag_q <= '0;
      err_q     <= 1'b0;
    end else begin
      last_b_q  <= last_b_d;
      m_valid_q <= m_valid_d;
      m_raddr_q <= m_raddr_d;
      m_rtag_q  <= m_rtag_d;
      inf_vld_q <= inf_vld_d;
      inf_tag_q <= inf_tag_d;
      err_q     <= err_d;
    end
  end

  assign bus.a_ready  = grant_a;
  assign bus.b_ready  = grant_b;
  assign bus.m_valid  = m_valid_q;
  assign bus.m_raddr  = m_raddr_q;
  assign bus.m_rtag   = m_rtag_q;
  assign bus.err      = err_q;

  assign bus.a_rvalid = oldest_vld & ~oldest_tag;
  assign bus.b_rvalid = oldest_vld & oldest_tag;
  assign bus.a_rdata  = bus.a_rvalid ? bus.m_rdata[15:0] : 16'h0000;
  assign bus.b_rdata  = bus.b_rvalid ? bus.m_rdata[15:0] : 16'h0000;

endmodule

// File: tb/tb_shared_read_arb.sv
// Directed bench for shared_read_arb with LAT=2 and a pipelined memory model that can
// corrupt the echoed tag of one return.
module tb_shared_read_arb;
  localparam int unsigned LAT = 2;

  logic clk;
  logic reset;
  logic corrupt;
  int   n_chk;
  int   n_pass;

  shared_read_arb_if bus ();

  shared_read_arb #(.LAT(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_rd(input logic [15:1] a);
    if (a == 15'h0010) return 16'hBEEF;
    return 16'h1000 + 16'(a);
  endfunction

  // Memory: address seen in cycle C returns {tag, data} in cycle C+LAT.
  logic [16:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= {bus.m_rtag ^ corrupt, mem_rd(bus.m_raddr)};
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.m_rdata = pipe[LAT-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk      = 0;
    n_pass     = 0;
    corrupt    = 1'b0;
    reset      = 1'b1;
    bus.a_req  = 1'b1;
    bus.b_req  = 1'b1;
    bus.a_addr = 15'h0001;
    bus.b_addr = 15'h0002;

    // Reset state, with both requests asserted.
    step();
    step();
    chk("rst_a_ready", 32'(bus.a_ready), 32'd0);
    chk("rst_b_ready", 32'(bus.b_ready), 32'd0);
    chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_m_raddr", 32'(bus.m_raddr), 32'd0);
    chk("rst_m_rtag", 32'(bus.m_rtag), 32'd0);
    chk("rst_rvalid", 32'({bus.a_rvalid, bus.b_rvalid}), 32'd0);
    chk("rst_rdata", 32'({bus.a_rdata, bus.b_rdata}), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    reset     = 1'b0;

    // Single read from A, address 0x0010.
    bus.a_req  = 1'b1;
    bus.a_addr = 15'h0010;
    #1;
    chk("t1_a_ready", 32'(bus.a_ready), 32'd1);
    chk("t1_b_ready", 32'(bus.b_ready), 32'd0);
    step();
    bus.a_req = 1'b0;
    #1;
    chk("t1_m_valid", 32'(bus.m_valid), 32'd1);
    chk("t1_m_raddr", 32'(bus.m_raddr), 32'h10);
    chk("t1_m_rtag", 32'(bus.m_rtag), 32'd0);
    chk("t1_a_ready_lo", 32'(bus.a_ready), 32'd0);
    step();
    #1;
    chk("t1_early_rvalid", 32'(bus.a_rvalid), 32'd0);
    chk("t1_m_idle", 32'({bus.m_valid, bus.m_raddr, bus.m_rtag}), 32'd0);
    step();
    #1;
    chk("t1_a_rvalid", 32'(bus.a_rvalid), 32'd1);
    chk("t1_a_rdata", 32'(bus.a_rdata), 32'hBEEF);
    chk("t1_b_quiet", 32'({bus.b_rvalid, bus.b_rdata}), 32'd0);
    step();
    #1;
    chk("t1_pulse_end", 32'({bus.a_rvalid, bus.a_rdata}), 32'd0);

    // Contention: fresh reset so A wins first, then strict alternation.
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.a_req  = (i < 6);
      bus.b_req  = (i < 6);
      bus.a_addr = 15'(32'h20 + (i + 1) / 2);
      bus.b_addr = 15'(32'h40 + i / 2);
      #1;
      chk($sformatf("rr_a_ready_%0d", i), 32'(bus.a_ready), 32'((i < 6) && (i % 2 == 0)));
      chk($sformatf("rr_b_ready_%0d", i), 32'(bus.b_ready), 32'((i < 6) && (i % 2 == 1)));
      if (i >= 1 && i <= 6) begin
        chk($sformatf("rr_m_rtag_%0d", i), 32'({bus.m_valid, bus.m_rtag}),
            32'(2 + (i - 1) % 2));
      end
      if (i >= 3 && i <= 8) begin
        if ((i - 3) % 2 == 0) begin
          chk($sformatf("rr_a_resp_%0d", i), 32'({bus.a_rvalid, bus.a_rdata}),
              32'h1_0000 + 32'h1020 + 32'((i - 3) / 2));
          chk($sformatf("rr_b_none_%0d", i), 32'({bus.b_rvalid, bus.b_rdata}), 32'd0);
        end else begin
          chk($sformatf("rr_b_resp_%0d", i), 32'({bus.b_rvalid, bus.b_rdata}),
              32'h1_0000 + 32'h1040 + 32'((i - 3) / 2));
          chk($sformatf("rr_a_none_%0d", i), 32'({bus.a_rvalid, bus.a_rdata}), 32'd0);
        end
      end else begin
        chk($sformatf("rr_idle_%0d", i), 32'({bus.a_rvalid, bus.b_rvalid}), 32'd0);
      end
      step();
    end

    // B alone, back-to-back addresses 1..4.
    bus.a_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.b_req  = (i < 4);
      bus.b_addr = 15'(i + 1);
      #1;
      chk($sformatf("bs_b_ready_%0d", i), 32'(bus.b_ready), 32'(i < 4));
      chk($sformatf("bs_a_rvalid_%0d", i), 32'(bus.a_rvalid), 32'd0);
      if (i >= 3 && i <= 6) begin
        chk($sformatf("bs_b_resp_%0d", i), 32'({bus.b_rvalid, bus.b_rdata}),
            32'h1_0000 + 32'h1000 + 32'(i - 2));
      end else begin
        chk($sformatf("bs_b_none_%0d", i), 32'(bus.b_rvalid), 32'd0);
      end
      step();
    end
    bus.b_req = 1'b0;

    // Wrong tag on one return from B.
    chk("tag_err_before", 32'(bus.err), 32'd0);
    bus.b_req  = 1'b1;
    bus.b_addr = 15'h0007;
    step();
    bus.b_req = 1'b0;
    corrupt   = 1'b1;
    step();
    corrupt = 1'b0;
    #1;
    chk("tag_err_early", 32'(bus.err), 32'd0);
    step();
    #1;
    chk("tag_b_resp", 32'({bus.b_rvalid, bus.b_rdata}), 32'h1_1007);
    chk("tag_a_none", 32'(bus.a_rvalid), 32'd0);
    step();
    #1;
    chk("tag_err_set", 32'(bus.err), 32'd1);
    bus.a_req  = 1'b1;
    bus.a_addr = 15'h0005;
    step();
    bus.a_req = 1'b0;
    repeat (3) step();
    chk("tag_err_sticky", 32'(bus.err), 32'd1);

    // Reset one cycle after two acceptances drops both reads.
    bus.a_req  = 1'b1;
    bus.a_addr = 15'h0030;
    step();
    bus.a_req  = 1'b0;
    bus.b_req  = 1'b1;
    bus.b_addr = 15'h0050;
    step();
    bus.b_req = 1'b0;
    reset     = 1'b1;
    #1;
    chk("mr_m_valid_rst", 32'(bus.m_valid), 32'd0);
    chk("mr_err_clr", 32'(bus.err), 32'd0);
    step();
    reset      = 1'b0;
    bus.a_req  = 1'b1;
    bus.a_addr = 15'h0033;
    #1;
    chk("mr_a_ready", 32'(bus.a_ready), 32'd1);
    chk("mr_stale0", 32'({bus.a_rvalid, bus.b_rvalid}), 32'd0);
    step();
    bus.a_req = 1'b0;
    for (int i = 1; i < 3; i++) begin
      #1;
      chk($sformatf("mr_stale%0d", i), 32'({bus.a_rvalid, bus.b_rvalid}), 32'd0);
      step();
    end
    #1;
    chk("mr_a_resp", 32'({bus.a_rvalid, bus.a_rdata}), 32'h1_1033);
    chk("mr_b_none", 32'(bus.b_rvalid), 32'd0);
    step();
    #1;
    chk("mr_pulse_end", 32'({bus.a_rvalid, bus.b_rvalid}), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
